gbuff_drain: RTL and testbench

Read-side drain engine for the output global buffer. After the TPU has filled the output SRAM with `m` result words, this block reads words 0..m-1 through the SRAM's synchronous read port. It streams them to the host/bench over a valid/ready interface, marks the final word, and pulses `done`. It is the consumer of the output-buffer write path and sits between the output SRAM and the host.

---
 rtl/gbuff_drain.sv | 137 +++++++++++++
 tb/tb_gbuff_drain.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbuff_drain.sv
// -----------------------------------------------------------------------------
// gbuff_drain
//
// Read-side drain engine for the output global buffer. Reads words 0..m-1 from
// the output SRAM through its synchronous read port. The words are streamed out
// over a valid/ready interface. A 3-deep prefetch FIFO absorbs host backpressure.
// The last word is flagged with out_last, and done pulses once the drain is
// complete.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous, active-low reset
//   start      one-cycle drain request, honoured only in IDLE
//   m          number of words to drain, captured with start
//   sram_ren   SRAM read enable
//   sram_addr  SRAM read address, {0, rd_idx}
//   sram_do    SRAM read data, valid the cycle after sram_ren
//   out_valid  out_data holds a word
//   out_data   streamed word (FIFO head)
//   out_last   marks the word at index m-1
//   out_ready  host accepts the word when out_valid && out_ready
//   busy       drain in progress
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module gbuff_drain #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 10,
  parameter int FIFO_D = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        m,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [WORD_W-1:0] sram_do,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [7:0]        m_q;
  logic [7:0]        rd_idx;
  logic [7:0]        tx_idx;
  logic              inflight;   // a read was issued last cycle; its data is on sram_do now
  logic [1:0]        fifo_count;
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [WORD_W-1:0] fifo_mem [FIFO_D];
  logic [2:0]        occupancy;
  logic              push;
  logic              pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'(FIFO_D - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads in flight are counted as already occupying a FIFO slot. This means a
  // returning word always has room, and the decision depends on registered
  // state only. out_ready therefore never reaches sram_ren or sram_addr.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
  assign sram_ren  = (state == RUN) && (rd_idx < m_q) && (occupancy < 3'(FIFO_D));
  assign sram_addr = {{(ADDR_W-8){1'b0}}, rd_idx};

  assign push      = inflight;
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && (tx_idx == m_q - 8'd1);
  assign pop       = out_valid && out_ready;

  // Decoded straight from the state register, so neither output glitches.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: every register here uses non-blocking assignments. All of them then
  // see pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      m_q        <= '0;
      rd_idx     <= '0;
      tx_idx     <= '0;
      inflight   <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      // NOTE: the FIFO storage is reset as well, although storage normally is
      // not. It is only three words, and this is what makes out_data read 0
      // during and straight after reset.
      for (int i = 0; i < FIFO_D; i++) fifo_mem[i] <= '0;
    end else begin
      inflight <= sram_ren;

      if (push) begin
        fifo_mem[wr_ptr] <= sram_do;
        wr_ptr           <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: ;  // idle, or push and pop together: count is unchanged
      endcase

      if (sram_ren) rd_idx <= rd_idx + 8'd1;
      if (pop)      tx_idx <= tx_idx + 8'd1;

      case (state)
        IDLE: begin
          if (start) begin
            m_q    <= m;
            rd_idx <= '0;
            tx_idx <= '0;
            state  <= (m == 8'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (pop && out_last) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gbuff_drain.sv
// -----------------------------------------------------------------------------
// tb_gbuff_drain
//
// Scoreboard bench for gbuff_drain. Each drain request pushes its expected
// words into a queue. A negedge monitor pops the queue on every handshake and
// compares the word against it. The monitor also checks the hold rule, read
// addresses and read-ahead depth. The directed tests check cycle timing, done
// and busy.
// -----------------------------------------------------------------------------
module tb_gbuff_drain;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        m = '0;
  logic              sram_ren;
  logic [ADDR_W-1:0] sram_addr;
  logic [WORD_W-1:0] sram_do = '0;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              done;

  gbuff_drain #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .FIFO_D(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .m         (m),
    .sram_ren  (sram_ren),
    .sram_addr (sram_addr),
    .sram_do   (sram_do),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM model.
  logic [WORD_W-1:0] sram_mem [256];
  always @(posedge clk) if (sram_ren) sram_do <= sram_mem[sram_addr[7:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;

  // Per-test statistics gathered by the monitor.
  int  base = 0;
  int  m_cur = 0;
  int  done_cnt = 0, hs_cnt = 0, rd_tot = 0, busy_cyc = 0;
  int  done_rel = -1, first_hs_rel = -1, last_hs_rel = -1;
  bit  any_valid = 0, any_ren = 0;
  int  rd_cnt [256];
  logic              prev_valid = 0, prev_ready = 0, prev_last = 0;
  logic [WORD_W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      if (sram_ren) begin
        rd_tot++;
        any_ren = 1;
        rd_cnt[sram_addr[7:0]]++;
        check("addr_in_range", sram_addr < m_cur, 1);
        check("outstanding_le3", (rd_tot - hs_cnt) <= 3, 1);
      end
      if (out_valid) any_valid = 1;
      if (busy) busy_cyc++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          sb_e = sb.pop_front();
          check("word_data", out_data, sb_e.data);
          check("word_last", out_last, sb_e.last);
        end
        if (hs_cnt == 0) first_hs_rel = cyc - base;
        last_hs_rel = cyc - base;
        hs_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_rel = cyc - base;
        check("done_after_all_words", sb.size(), 0);
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  int pat [6] = '{1, 0, 0, 1, 0, 1};

  task automatic clear_stats();
    done_cnt = 0; hs_cnt = 0; rd_tot = 0; busy_cyc = 0;
    done_rel = -1; first_hs_rel = -1; last_hs_rel = -1;
    any_valid = 0; any_ren = 0;
    foreach (rd_cnt[i]) rd_cnt[i] = 0;
  endtask

  // Cycle 0 is the cycle start is high in; returns 1 ns into cycle 1.
  task automatic start_drain(input logic [7:0] mm);
    @(posedge clk); #1;
    start = 1'b1;
    m     = mm;
    base  = cyc;
    m_cur = int'(mm);
    for (int i = 0; i < int'(mm); i++)
      sb.push_back(exp_t'{data: sram_mem[i], last: (i == int'(mm) - 1)});
    @(posedge clk); #1;
    start = 1'b0;
    m     = ~mm;  // later changes to m must not matter
  endtask

  task automatic run_to_done(input int max_cyc, input bit toggle);
    int k = 0;
    while (done_cnt == 0 && k < max_cyc) begin
      out_ready = toggle ? (pat[k % 6] != 0) : 1'b1;
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b1;
    check("done_within_bound", done_cnt > 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      sram_mem[i] = (i < 4) ? 32'h10 + i : 32'h5A00_0000 | (i * 32'h0101);

    // Reset state
    #12;
    check("rst_sram_ren", sram_ren, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Test 1: m=4, out_ready always high
    out_ready = 1'b1;
    clear_stats();
    start_drain(8'd4);
    run_to_done(20, 1'b0);
    check("t1_first_word_cycle", first_hs_rel, 3);
    check("t1_last_word_cycle", last_hs_rel, 6);
    check("t1_done_cycle", done_rel, 7);
    check("t1_words", hs_cnt, 4);
    check("t1_busy_cycles", busy_cyc, 6);
    check("t1_done_once", done_cnt, 1);
    for (int i = 0; i < 4; i++) check("t1_read_once", rd_cnt[i], 1);
    check("t1_sb_empty", sb.size(), 0);

    // Test 2: m=8, out_ready toggling 1,0,0,1,0,1,...
    clear_stats();
    start_drain(8'd8);
    run_to_done(100, 1'b1);
    check("t2_words", hs_cnt, 8);
    check("t2_reads", rd_tot, 8);
    check("t2_done_once", done_cnt, 1);
    for (int i = 0; i < 8; i++) check("t2_read_once", rd_cnt[i], 1);
    check("t2_sb_empty", sb.size(), 0);

    // Test 3: m=0
    clear_stats();
    start_drain(8'd0);
    @(negedge clk);
    check("t3_done_cycle1", done, 1);
    check("t3_busy_cycle1", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t3_done_once", done_cnt, 1);
    check("t3_done_rel", done_rel, 1);
    check("t3_no_valid", any_valid, 0);
    check("t3_no_ren", any_ren, 0);
    check("t3_no_busy", busy_cyc, 0);

    // Test 4: m=1, host stalls 5 cycles
    clear_stats();
    out_ready = 1'b0;
    start_drain(8'd1);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall_valid", out_valid, 1);
      check("t4_stall_last", out_last, 1);
      check("t4_stall_data", out_data, 32'h10);
    end
    @(posedge clk); #1;
    run_to_done(10, 1'b0);
    check("t4_hs_cycle", last_hs_rel, 8);
    check("t4_done_cycle", done_rel, 9);
    check("t4_done_once", done_cnt, 1);

    // Test 5: second start during an m=6 drain is ignored
    clear_stats();
    out_ready = 1'b1;
    start_drain(8'd6);
    start = 1'b1;
    m     = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    run_to_done(30, 1'b0);
    check("t5_words", hs_cnt, 6);
    check("t5_reads", rd_tot, 6);
    check("t5_done_once", done_cnt, 1);
    check("t5_sb_empty", sb.size(), 0);

    // Test 6: asynchronous reset after 3 of 6 words, then a fresh m=2 drain
    clear_stats();
    start_drain(8'd6);
    for (int k = 0; k < 50 && hs_cnt < 3; k++) @(negedge clk);
    check("t6_three_words", hs_cnt >= 3, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("t6_rst_sram_ren", sram_ren, 0);
    check("t6_rst_sram_addr", sram_addr, 0);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_out_last", out_last, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_done_after_abort", done_cnt, 0);
    rst = 1'b1;
    sram_mem[0] = 32'hCAFE_0000;
    sram_mem[1] = 32'hCAFE_0001;
    clear_stats();
    start_drain(8'd2);
    run_to_done(20, 1'b0);
    check("t6_words", hs_cnt, 2);
    check("t6_read_addr0", rd_cnt[0], 1);
    check("t6_read_addr1", rd_cnt[1], 1);
    check("t6_done_once", done_cnt, 1);
    check("t6_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
